// File: rtl/buffered_uart_rx_if.sv
// Consumer-side bundle of buffered_uart_rx: FIFO read port plus the sticky error flags.
// The receiver uses the slave modport, the byte consumer the master modport.
interface buffered_uart_rx_if;
  logic [7:0] data;
  logic       empty;
  logic       rd_en;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;
  logic       clr_err;

  modport master (
    input  data, empty, overrun, frame_err, parity_err,
    output rd_en, clr_err
  );

  modport slave (
    output data, empty, overrun, frame_err, parity_err,
    input  rd_en, clr_err
  );
endinterface

// File: rtl/buffered_uart_rx.sv
// Oversampling UART receiver (8N1, or 8E1 when BUFFERED_UART_RX_PARITY_EN is defined) that
// pushes each good byte into a show-ahead FIFO and keeps sticky overrun/framing/parity flags.
module buffered_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  buffered_uart_rx_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned     Depth    = 2 ** ADDR_W;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef BUFFERED_UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  logic            rx_meta_q, rx_s_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            stop_evt, par_ok, push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef BUFFERED_UART_RX_PARITY_EN
  logic par_q;
  assign par_ok = ~((^shift_q) ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  assign stop_evt = (state_q == StStop) && (cnt_q == BitLast);
  assign push     = stop_evt & rx_s_q & par_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef BUFFERED_UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            // A line that is high again at mid start bit was only a glitch.
            state_q <= rx_s_q ? StIdle : StData;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef BUFFERED_UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`ifdef BUFFERED_UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            par_q   <= rx_s_q;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`endif
        StStop: begin
          // Back to idle on the sample edge so a following start bit is caught on time.
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [ADDR_W:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]      mem_q [Depth];
  logic            empty, full, do_pop, do_push, ovr_set, fe_set;
  logic            ovr_q, fe_q;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign do_pop  = bus.rd_en & ~empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still takes the byte.
  assign do_push = push & (~full | do_pop);
  assign ovr_set = push & full & ~do_pop;
  assign fe_set  = stop_evt & ~rx_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[ADDR_W-1:0]] <= shift_q;
        wr_ptr_q                    <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      ovr_q <= ovr_set | (ovr_q & ~bus.clr_err);
      fe_q  <= fe_set | (fe_q & ~bus.clr_err);
    end
  end

`ifdef BUFFERED_UART_RX_PARITY_EN
  logic pe_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_q <= 1'b0;
    end else begin
      pe_q <= (stop_evt & rx_s_q & ~par_ok) | (pe_q & ~bus.clr_err);
    end
  end
  assign bus.parity_err = pe_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data      = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign bus.empty     = empty;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = fe_q;

endmodule

// File: tb/tb_buffered_uart_rx.sv
// Bench for buffered_uart_rx: vector table, hand-written corner sequences and random frames
// checked against a frame-level queue model.
module tb_buffered_uart_rx;

  localparam int Cpb   = 8;
  localparam int AddrW = 2;
  localparam int Depth = 4;
  localparam int Half  = Cpb / 2;
`ifdef BUFFERED_UART_RX_PARITY_EN
  localparam int FrameBits = 11;
  localparam bit ParEn     = 1'b1;
`else
  localparam int FrameBits = 10;
  localparam bit ParEn     = 1'b0;
`endif
  // Pin falls just before edge 1 of a frame; rx_s is first seen low at edge 3 (E).
  localparam int StopEdge = 3 + Half + (FrameBits - 1) * Cpb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_rx = 1'b1;

  buffered_uart_rx_if bus ();

  buffered_uart_rx #(
    .CLKS_PER_BIT(Cpb),
    .ADDR_W      (AddrW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .uart_rx(uart_rx),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic       m_ovr = 1'b0, m_fe = 1'b0, m_pe = 1'b0;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       flip;
    logic       exp_push;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_state(input string tag);
    chk({tag, " empty"}, 32'(bus.empty), 32'(q.size() == 0));
    if (q.size() != 0) chk({tag, " data"}, 32'(bus.data), 32'(q[0]));
    chk({tag, " overrun"}, 32'(bus.overrun), 32'(m_ovr));
    chk({tag, " frame_err"}, 32'(bus.frame_err), 32'(m_fe));
    chk({tag, " parity_err"}, 32'(bus.parity_err), 32'(m_pe));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      uart_rx = 1'b1;
    end
  endtask

  // Drives one frame; t_ne is the first negedge index at which empty was seen low.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic flip,
                            input int pop_at, input int clr_at, output int t_ne);
    logic [FrameBits-1:0] frame;
`ifdef BUFFERED_UART_RX_PARITY_EN
    frame = {stop, (^b) ^ flip, b, 1'b0};
`else
    frame = {stop, b, 1'b0};
`endif
    t_ne = -1;
    for (int k = 0; k < FrameBits * Cpb; k++) begin
      @(negedge clk);
      if (t_ne < 0 && !bus.empty) t_ne = k;
      uart_rx = frame[k / Cpb];
      if (pop_at >= 0) bus.rd_en = (k == pop_at);
      if (clr_at >= 0) bus.clr_err = (k == clr_at);
    end
  endtask

  task automatic send_model(input logic [7:0] b, input logic stop, input logic flip,
                            input logic pop_same, input logic clr_same);
    int t;
    send_frame(b, stop, flip, pop_same ? StopEdge - 1 : -1, clr_same ? StopEdge - 1 : -1, t);
    if (pop_same && q.size() != 0) void'(q.pop_front());
    if (clr_same) begin
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      m_pe  = 1'b0;
    end
    if (!stop) m_fe = 1'b1;
    else if (ParEn && flip) m_pe = 1'b1;
    else if (q.size() < Depth) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic pop_model();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_flags();
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    m_pe  = 1'b0;
  endtask

  initial begin
    int t;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h03, 1'b1, 1'b1, !ParEn, 1'b0, ParEn};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;

    // Reset defaults, then a long idle period.
    repeat (3) @(negedge clk);
    chk("reset data", 32'(bus.data), 32'h00);
    compare_state("reset");
    rst = 1'b1;
    idle(100);
    chk("idle data", 32'(bus.data), 32'h00);
    compare_state("idle");

    // Single byte with exact push latency.
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1, t);
    chk("first byte latency", 32'(t), 32'(StopEdge));
    chk("first byte data", 32'(bus.data), 32'hA5);
    q.push_back(8'hA5);
    pop_model();
    compare_state("after pop");

    // Table of single frames from an empty FIFO.
    for (int i = 0; i < 6; i++) begin
      clear_flags();
      send_frame(vecs[i].b, vecs[i].stop, vecs[i].flip, -1, -1, t);
      idle(12);
      chk($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(!vecs[i].exp_push));
      if (vecs[i].exp_push) chk($sformatf("vec%0d data", i), 32'(bus.data), 32'(vecs[i].b));
      chk($sformatf("vec%0d frame_err", i), 32'(bus.frame_err), 32'(vecs[i].exp_fe));
      chk($sformatf("vec%0d parity_err", i), 32'(bus.parity_err), 32'(vecs[i].exp_pe));
      if (vecs[i].exp_push) begin
        @(negedge clk) bus.rd_en = 1'b1;
        @(negedge clk) bus.rd_en = 1'b0;
      end
    end
    clear_flags();
    compare_state("table end");

    // Back-to-back frames overflow a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) send_model(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("b2b overrun", 32'(bus.overrun), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("b2b data%0d", i), 32'(bus.data), 32'(i));
      pop_model();
    end
    chk("b2b empty", 32'(bus.empty), 32'h1);
    clear_flags();
    compare_state("b2b clr");

    // Push into a full FIFO on the same edge as a pop is accepted.
    for (int i = 0; i < Depth; i++) send_model(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    send_model(8'hEE, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    compare_state("full push+pop");
    chk("full push+pop head", 32'(bus.data), 32'h11);
    while (q.size() != 0) pop_model();
    compare_state("drained");

    // Framing error with clr_err on the same edge: set wins.
    send_model(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(12);
    compare_state("fe vs clr");
    clear_flags();

    // Glitch rejection and pop while empty.
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk);
    @(negedge clk) uart_rx = 1'b1;
    idle(30);
    compare_state("glitch");
    pop_model();
    compare_state("pop empty");

    // Random frames, pops and clears against the queue model.
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        send_model(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        idle(12);
      end else if (r <= 8) begin
        pop_model();
      end else begin
        clear_flags();
      end
      compare_state($sformatf("rand%0d", i));
    end

    // Reset in the middle of a frame with bytes and flags pending.
    send_model(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    send_model(8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(12);
    @(negedge clk) uart_rx = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b0;
    uart_rx = 1'b1;
    q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    m_pe  = 1'b0;
    @(negedge clk);
    compare_state("rst mid");
    chk("rst mid data", 32'(bus.data), 32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(10);
    send_model(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    compare_state("after rst");
    chk("after rst data", 32'(bus.data), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
